// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Purpose : request/response bundle between the core's MEM stage and the
//           data-memory responder.
// Signals : req_valid/req_ready    - request handshake
//           req_write              - 1 = store word, 0 = load word
//           req_addr / req_wdata   - byte address and store data
//           resp_valid             - one-cycle completion pulse
//           resp_rdata / resp_err  - load data and access error flag
//           busy                   - a request is accepted and not yet answered
// Modports: master = requester (core side), slave = responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Purpose : multi-cycle data memory serving one load/store at a time with a
//           fixed access latency, flagging misaligned and out-of-range accesses.
// Params  : LATENCY     - cycles from acceptance to resp_valid (1..15)
//           DEPTH_WORDS - number of 32-bit words (power of two)
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - request/response bundle (slave side), see dmem_responder_if
module dmem_responder #(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    // The array survives reset; it only starts out zeroed at power-up.
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

    logic          w_accept;
    logic          w_commit;
    logic          w_cmdWrite;
    logic [31:0]   w_cmdAddr;
    logic [31:0]   w_cmdWdata;
    logic          w_cmdErr;
    logic [AW-1:0] w_wordIdx;

    assign w_accept = (r_state == IDLE) && bus.req_valid && !rst;

    // With LATENCY=1 the commit edge is the acceptance edge, so the command
    // must come straight from the bus instead of the capture registers.
    assign w_cmdWrite = (r_state == IDLE) ? bus.req_write : r_write;
    assign w_cmdAddr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_cmdWdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    // Any address bit above the array (bits AW+2 and up) means out of range.
    assign w_cmdErr  = (w_cmdAddr[1:0] != 2'b00) || ((w_cmdAddr >> (AW + 2)) != 32'd0);
    assign w_wordIdx = w_cmdAddr[AW+1:2];

    // The access happens on the edge that enters RESP; reset on that edge kills it.
    assign w_commit = !rst && (r_state != RESP) && (w_next == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= CNT_INIT;
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response data/error are only non-zero during the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_cmdErr;
            r_rdata <= (!w_cmdErr && !w_cmdWrite) ? r_mem[w_wordIdx] : 32'd0;
        end else begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_cmdWrite && !w_cmdErr) begin
            r_mem[w_wordIdx] <= w_cmdWdata;
        end
    end

    always_comb begin
        bus.req_ready  = (r_state == IDLE) && !rst;
        bus.resp_valid = (r_state == RESP) && !rst;
        bus.busy       = ((r_state == WAIT) || (r_state == RESP)) && !rst;
        bus.resp_rdata = r_rdata;
        bus.resp_err   = r_err;
    end

endmodule
